// File: rtl/avmm_data_arbiter.sv
// Two-requester Avalon-MM data-port arbiter: round-robin command grant, write-burst
// lock, and an in-order pending-read FIFO that steers returning read beats.
module avmm_data_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 4,
  parameter int MAX_PEND = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*ADDR_W-1:0]  rq_addr,
  input  logic [1:0]           rq_read,
  input  logic [1:0]           rq_write,
  input  logic [2*DATA_W-1:0]  rq_writedata,
  input  logic [2*BURST_W-1:0] rq_burstcount,
  output logic [1:0]           rq_waitrequest,
  output logic [DATA_W-1:0]    rq_readdata,
  output logic [1:0]           rq_readdatavalid,
  output logic [ADDR_W-1:0]    s_addr,
  output logic                 s_read,
  output logic                 s_write,
  output logic [DATA_W-1:0]    s_writedata,
  output logic [BURST_W-1:0]   s_burstcount,
  input  logic                 s_waitrequest,
  input  logic [DATA_W-1:0]    s_readdata,
  input  logic                 s_readdatavalid,
  output logic                 err
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {IDLE, CMD, WBURST} state_t;

  function automatic logic [BURST_W-1:0] norm_bc(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  state_t               state, state_nxt;
  logic                 grant, grant_nxt;
  logic                 prio_one, prio_one_nxt;   // 1: requester 1 wins a tie
  logic [BURST_W-1:0]   wlen, wlen_nxt;
  logic [BURST_W-1:0]   wcnt, wcnt_nxt;
  logic [BURST_W-1:0]   rbeat, rbeat_nxt;

  logic                 fifo_id  [MAX_PEND];
  logic [BURST_W-1:0]   fifo_len [MAX_PEND];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic                 proto_err, spurious;

  logic [1:0]           eligible;
  logic                 pick;
  logic [ADDR_W-1:0]    g_addr;
  logic [DATA_W-1:0]    g_wdata;
  logic [BURST_W-1:0]   g_bc;
  logic                 g_read, g_write;
  logic                 head_id;
  logic [BURST_W-1:0]   head_len;

  assign fifo_full  = (fifo_cnt == CNT_W'(MAX_PEND));
  assign fifo_empty = (fifo_cnt == '0);
  assign head_id    = fifo_id[rd_ptr];
  assign head_len   = fifo_len[rd_ptr];

  assign g_addr  = grant ? rq_addr[2*ADDR_W-1:ADDR_W]        : rq_addr[ADDR_W-1:0];
  assign g_wdata = grant ? rq_writedata[2*DATA_W-1:DATA_W]   : rq_writedata[DATA_W-1:0];
  assign g_bc    = grant ? rq_burstcount[2*BURST_W-1:BURST_W] : rq_burstcount[BURST_W-1:0];
  assign g_read  = rq_read[grant];
  assign g_write = rq_write[grant];

  assign rq_readdata = s_readdata;

  // A read-and-write request is treated as a read, so it obeys the FIFO-full block.
  always_comb begin
    for (int r = 0; r < 2; r++)
      eligible[r] = rq_read[r] ? !fifo_full : rq_write[r];
    pick = (&eligible) ? prio_one : eligible[1];
  end

  // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    prio_one_nxt   = prio_one;
    wlen_nxt       = wlen;
    wcnt_nxt       = wcnt;
    rq_waitrequest = 2'b11;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_addr         = g_addr;
    s_writedata    = g_wdata;
    s_burstcount   = g_bc;
    push           = 1'b0;
    proto_err      = 1'b0;

    unique case (state)
      IDLE: begin
        if (|eligible) begin
          grant_nxt    = pick;
          prio_one_nxt = ~pick;
          state_nxt    = CMD;
        end
      end
      CMD: begin
        rq_waitrequest[grant] = s_waitrequest;
        s_read    = g_read;
        s_write   = g_write & ~g_read;
        proto_err = g_read & g_write;
        if (g_read && !s_waitrequest) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else if (s_write && !s_waitrequest) begin
          if (norm_bc(g_bc) == BURST_W'(1)) begin
            state_nxt = IDLE;
          end else begin
            wlen_nxt  = norm_bc(g_bc);
            wcnt_nxt  = BURST_W'(1);
            state_nxt = WBURST;
          end
        end else if (!g_read && !g_write) begin
          state_nxt = IDLE;   // requester withdrew before acceptance
        end
      end
      WBURST: begin
        rq_waitrequest[grant] = s_waitrequest;
        s_write   = g_write;
        proto_err = g_read & g_write;
        if (g_write && !s_waitrequest) begin
          wcnt_nxt = wcnt + BURST_W'(1);
          if (wcnt + BURST_W'(1) == wlen) begin
            wcnt_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read return path: zero-latency steering to the FIFO head's owner.
  always_comb begin
    rq_readdatavalid = 2'b00;
    rbeat_nxt        = rbeat;
    pop              = 1'b0;
    spurious         = 1'b0;
    if (s_readdatavalid) begin
      if (fifo_empty) begin
        spurious = 1'b1;
      end else begin
        rq_readdatavalid[head_id] = 1'b1;
        if (rbeat + BURST_W'(1) == head_len) begin
          pop       = 1'b1;
          rbeat_nxt = '0;
        end else begin
          rbeat_nxt = rbeat + BURST_W'(1);
        end
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio_one <= 1'b0;
      wlen     <= '0;
      wcnt     <= '0;
      rbeat    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      prio_one <= prio_one_nxt;
      wlen     <= wlen_nxt;
      wcnt     <= wcnt_nxt;
      rbeat    <= rbeat_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      err <= err | proto_err | spurious;
    end
  end

  // NOTE: FIFO storage is not reset; the reset occupancy count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_id[wr_ptr]  <= grant;
      fifo_len[wr_ptr] <= norm_bc(g_bc);
    end
  end

endmodule
